pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the payload width in bits (the lc3b_control_word-plus-datapath bundle is carried by setting WIDTH accordingly).
REQ-002 SHALL have parameter CLEAR_ON_FLUSH, default 0; when 1, the data registers are zeroed on flush.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream holds a valid payload.
REQ-006 SHALL have port in_ready  output  1  stage accepts a payload this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data is valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  payload to downstream.
REQ-011 SHALL have port flush  input  1  discard all held and incoming payloads.
REQ-012 SHALL have port occupancy  output  2  entries held, 0 to 2.

Function
REQ-013 SHALL form a 2-entry skid stage: main register drives out_data; skid register absorbs one payload when downstream stalls.
REQ-014 SHALL define input fire as in_valid && in_ready and output fire as out_valid && out_ready.
REQ-015 SHALL implement states EMPTY (0 entries), BUSY (main only) and FULL (main plus skid).
REQ-016 EMPTY: on input fire, load main and go to BUSY; otherwise stay.
REQ-017 BUSY: input and output fire together, load main and stay; input fire only, load skid and go to FULL; output fire only, go to EMPTY.
REQ-018 FULL: on output fire, copy skid to main and go to BUSY; otherwise hold.
REQ-019 SHALL decode in_ready as (state != FULL) from the state register only, with no combinational path from out_ready or in_valid.
REQ-020 SHALL decode out_valid as (state != EMPTY), and occupancy as 0, 1 or 2 per state.
REQ-021 SHALL give one-cycle latency: a payload accepted in EMPTY appears on out_data with out_valid=1 on the next cycle.
REQ-022 SHALL sustain one transfer per cycle while out_ready stays high.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL preserve order: a skid payload never overtakes the main payload.
REQ-025 On flush=1, SHALL enter EMPTY next cycle, dropping held payloads and any same-cycle input.
REQ-026 Flush SHALL take priority over simultaneous input and output fire; the output fire in that cycle still counts as delivered downstream.
REQ-027 With CLEAR_ON_FLUSH=1, SHALL zero main and skid on flush; with 0, data registers keep their values.

Reset
REQ-028 reset=1 at a rising clk edge SHALL force EMPTY, main=0 and skid=0, giving out_valid=0, out_data=0, occupancy=0 and in_ready=1 the next cycle.
REQ-029 Reset SHALL override flush and all handshakes, including mid-transfer in FULL.

Configuration
REQ-030 With PIPE_STAGE_PERF_EN defined, SHALL add output stall_cycles (16 bits): counts cycles with out_valid=1 and out_ready=0, saturates at 16'hFFFF, and clears on reset (not on flush).
REQ-031 Without PIPE_STAGE_PERF_EN, the stall_cycles port and its counter SHALL not exist.

Structure
REQ-032 SHALL put the state enum (pipe_stage_state_t: EMPTY, BUSY, FULL) in package lc3b_types.
REQ-033 SHALL implement main and skid as two instances of sub-module pipe_stage_slot (WIDTH-bit register with load, sync reset and clear).
REQ-034 The handshake FSM and the optional counter SHALL live in pipe_stage itself.

Verification
REQ-035 Reset then in_valid=1 with in_data=16'h1234 and out_ready=1: out_valid=1 and out_data=16'h1234 one cycle later, occupancy=1.
REQ-036 Stream 16'h0001 to 16'h0008 with out_ready=1 throughout: eight consecutive output fires in order, in_ready never 0.
REQ-037 out_ready=0 and send 16'hAAAA then 16'hBBBB: occupancy=2, in_ready=0; raise out_ready: AAAA then BBBB on consecutive cycles.
REQ-038 In FULL, assert flush together with in_valid carrying 16'hCCCC: next cycle out_valid=0, occupancy=0, in_ready=1, and CCCC is never output.
REQ-039 In FULL, assert reset and flush together: next cycle out_data=0 and out_valid=0.
REQ-040 With PIPE_STAGE_PERF_EN, hold out_ready=0 for 5 cycles with out_valid=1: stall_cycles=5.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions.
//
// Contents:
//   pipe_stage_state_t : occupancy state of a two-entry skid pipeline stage
//                        EMPTY = no entries, BUSY = main register only,
//                        FULL  = main plus skid register.
package lc3b_types;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_stage_state_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One payload register of a pipeline stage.
//
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset, zeroes the register
//   load_i  : capture d_i on the next rising edge
//   clear_i : zero the register on the next rising edge (wins over load_i)
//   d_i     : payload to capture
//   q_o     : held payload
module pipe_stage_slot #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] dataQ;

  // Reset and clear both force zero; otherwise the register only changes
  // when explicitly loaded, so held payloads stay stable while stalled.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      dataQ <= '0;
    end else if (load_i) begin
      dataQ <= d_i;
    end
  end

  assign q_o = dataQ;

endmodule

// File: rtl/pipe_stage.sv
// Two-entry skid pipeline stage with valid/ready handshakes on both sides.
//
// The main register always drives out_data. When the downstream stalls
// while a new payload is accepted, that payload lands in the skid register
// and is moved into main once the main payload has been delivered.
// in_ready depends only on the state register, so there is no combinational
// path from out_ready or in_valid to in_ready.
//
// Parameters:
//   WIDTH          : payload width in bits
//   CLEAR_ON_FLUSH : 1 = zero main and skid on flush, 0 = leave them as-is
//
// Ports:
//   clk, reset     : clock (rising edge) and synchronous active-high reset
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   flush          : discard everything held plus any same-cycle input
//   occupancy      : number of held entries (0..2)
//   stall_cycles   : only when PIPE_STAGE_PERF_EN is defined; saturating
//                    count of cycles with out_valid=1 and out_ready=0
module pipe_stage
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter bit          CLEAR_ON_FLUSH = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  pipe_stage_state_t stateQ;

  logic             inFire;
  logic             outFire;
  logic             mainLoad;
  logic             mainFromSkid;
  logic             skidLoad;
  logic             clearSlots;
  logic [WIDTH-1:0] mainD;
  logic [WIDTH-1:0] skidQ;

  assign in_ready  = (stateQ != FULL);
  assign out_valid = (stateQ != EMPTY);
  assign inFire    = in_valid && in_ready;
  assign outFire   = out_valid && out_ready;

  // A flush drops payloads, so the data registers are either zeroed or
  // simply left alone; out_valid=0 afterwards hides whatever they hold.
  assign clearSlots = flush && CLEAR_ON_FLUSH;

  // Occupancy is a pure decode of the state register.
  always_comb begin
    occupancy = 2'd0;
    case (stateQ)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Decide which registers load this cycle. Main takes the new payload
  // whenever it is (or is about to become) free; skid only catches a
  // payload that arrives while main is stalled. In FULL, delivering main
  // promotes skid into main so order is preserved. Flush suppresses all
  // loads because the same-cycle input is discarded too.
  always_comb begin
    mainLoad     = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    if (!flush) begin
      case (stateQ)
        EMPTY: mainLoad = inFire;
        BUSY: begin
          if (inFire && outFire) begin
            mainLoad = 1'b1;
          end else if (inFire) begin
            skidLoad = 1'b1;
          end
        end
        FULL: begin
          if (outFire) begin
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mainD = mainFromSkid ? skidQ : in_data;

  // Handshake FSM. Reset beats flush, and flush beats any handshake; an
  // output fire in a flush cycle has still been taken by the downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= EMPTY;
    end else if (flush) begin
      stateQ <= EMPTY;
    end else begin
      case (stateQ)
        EMPTY: begin
          if (inFire) stateQ <= BUSY;
        end
        BUSY: begin
          if (inFire && !outFire) begin
            stateQ <= FULL;
          end else if (!inFire && outFire) begin
            stateQ <= EMPTY;
          end
        end
        FULL: begin
          if (outFire) stateQ <= BUSY;
        end
        default: stateQ <= EMPTY;
      endcase
    end
  end

  pipe_stage_slot #(.WIDTH(WIDTH)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (mainLoad),
    .clear_i (clearSlots),
    .d_i     (mainD),
    .q_o     (out_data)
  );

  pipe_stage_slot #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skidLoad),
    .clear_i (clearSlots),
    .d_i     (in_data),
    .q_o     (skidQ)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stallQ;

  // Count cycles where a payload is offered but not taken. Saturates so a
  // long stall never wraps back to a small value; flush does not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallQ <= 16'd0;
    end else if (out_valid && !out_ready && (stallQ != 16'hFFFF)) begin
      stallQ <= stallQ + 16'd1;
    end
  end

  assign stall_cycles = stallQ;
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage (WIDTH=16, CLEAR_ON_FLUSH=0).
// Define PIPE_STAGE_PERF_EN to also exercise the stall counter.
module tb_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        flush;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int tests = 0;
  int fails = 0;
  int outCount = 0;
  bit sawCccc = 1'b0;
  logic [15:0] expQ[$];

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(16), .CLEAR_ON_FLUSH(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Single comparison point: counts the test and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge,
  // well away from the next active edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor on the falling edge, where all signals are settled.
  // Delivered payloads are popped before new ones are pushed so the
  // simultaneous in/out case keeps order; flush drops everything queued
  // after counting any same-cycle delivery.
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
    end else begin
      if (out_valid && out_ready) begin
        outCount++;
        if (out_data == 16'hCCCC) sawCccc = 1'b1;
        if (expQ.size() == 0) begin
          checkOutput("sb_unexpected_output", {16'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("sb_data", {16'h0, out_data}, {16'h0, expQ.pop_front()});
        end
      end
      if (flush) begin
        expQ.delete();
      end else if (in_valid && in_ready) begin
        expQ.push_back(in_data);
      end
    end
  end

  initial begin
    int startCount;

    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0; flush = 1'b0;
    applyStimulus(2);
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_out_data",  {16'h0, out_data},  32'h0);
    checkOutput("rst_occupancy", {30'h0, occupancy}, 32'h0);
    checkOutput("rst_in_ready",  {31'h0, in_ready},  32'h1);
    reset = 1'b0;

    // Single payload, one-cycle latency
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    applyStimulus(1);
    in_valid = 1'b0;
    checkOutput("lat_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("lat_out_data",  {16'h0, out_data},  32'h1234);
    checkOutput("lat_occupancy", {30'h0, occupancy}, 32'h1);
    applyStimulus(1);
    checkOutput("lat_drained", {30'h0, occupancy}, 32'h0);

    // Full-rate stream
    startCount = outCount;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      checkOutput("stream_in_ready", {31'h0, in_ready}, 32'h1);
      applyStimulus(1);
    end
    in_valid = 1'b0;
    applyStimulus(2);
    checkOutput("stream_count", outCount - startCount, 32'd8);

    // Backpressure into FULL, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hAAAA;
    applyStimulus(1);
    in_data = 16'hBBBB;
    applyStimulus(1);
    in_valid = 1'b0;
    checkOutput("full_occupancy", {30'h0, occupancy}, 32'h2);
    checkOutput("full_in_ready",  {31'h0, in_ready},  32'h0);
    checkOutput("full_out_data",  {16'h0, out_data},  32'hAAAA);
    applyStimulus(1);
    checkOutput("stall_hold_data", {16'h0, out_data}, 32'hAAAA);
    out_ready = 1'b1;
    applyStimulus(1);
    checkOutput("drain_second", {16'h0, out_data},  32'hBBBB);
    checkOutput("drain_occ",    {30'h0, occupancy}, 32'h1);
    applyStimulus(1);
    checkOutput("drain_empty", {31'h0, out_valid}, 32'h0);

    // Flush in FULL with a same-cycle input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111;
    applyStimulus(1);
    in_data = 16'h2222;
    applyStimulus(1);
    flush = 1'b1; in_data = 16'hCCCC;
    applyStimulus(1);
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("flush_occupancy", {30'h0, occupancy}, 32'h0);
    checkOutput("flush_in_ready",  {31'h0, in_ready},  32'h1);
    checkOutput("flush_keeps_data", {16'h0, out_data}, 32'h1111);
    out_ready = 1'b1;
    applyStimulus(3);
    checkOutput("flush_no_cccc", {31'h0, sawCccc}, 32'h0);

    // Flush while main is being delivered: delivery counts, skid is dropped
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h3333;
    applyStimulus(1);
    in_data = 16'h4444;
    applyStimulus(1);
    in_valid = 1'b0;
    startCount = outCount;
    out_ready = 1'b1; flush = 1'b1;
    applyStimulus(1);
    flush = 1'b0;
    checkOutput("flush_fire_count", outCount - startCount, 32'd1);
    checkOutput("flush_fire_empty", {31'h0, out_valid}, 32'h0);
    applyStimulus(2);

    // Reset together with flush in FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h5A5A;
    applyStimulus(1);
    in_data = 16'hA5A5;
    applyStimulus(1);
    reset = 1'b1; flush = 1'b1;
    applyStimulus(1);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checkOutput("rstflush_out_data",  {16'h0, out_data},  32'h0);
    checkOutput("rstflush_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rstflush_in_ready",  {31'h0, in_ready},  32'h1);

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter: load one payload, then stall five cycles
    checkOutput("perf_reset", {16'h0, stall_cycles}, 32'h0);
    in_valid = 1'b1; in_data = 16'h7777;
    applyStimulus(1);
    in_valid = 1'b0;
    applyStimulus(5);
    checkOutput("perf_stall5", {16'h0, stall_cycles}, 32'd5);
    out_ready = 1'b1;
    applyStimulus(2);
    checkOutput("perf_hold", {16'h0, stall_cycles}, 32'd5);
`endif

    out_ready = 1'b1;
    applyStimulus(2);
    checkOutput("sb_final_empty", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
